conv_frame_mem: RTL and testbench
=================================

# conv_frame_mem

Frame-memory responder and host I/O for `conv2d`. Holds one 50×50 input frame and one result frame, and serves `conv2d`'s read port (`ReadAddress`/`d_in`) and write port (`WriteAddress`/`d_out`/`WriteEnable`). A host fills the input frame through a valid/ready load stream, starts the convolution, and drains results through a valid/ready output stream. This replaces the bench-only memory model with synthesizable logic.

## Interface
- `IMG_W`, 50, frame width in pixels
- `IMG_H`, 50, frame height in pixels
- `PIX_W`, 12, input pixel width
- `OUT_W`, 20, result width (`PIX_W` + 8)
- `ADDR_W`, 17, `conv2d` address width

- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `go` in 1: host command, sampled only in IDLE
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse when the last result word is accepted on the output stream
- `s_valid` in 1, `s_ready` out 1, `s_data` in `PIX_W`: load stream, raster order
- `m_valid` out 1, `m_ready` in 1, `m_data` out `OUT_W`, `m_last` out 1: result stream, raster order
- `conv_start` out 1: one-cycle start pulse to `conv2d.start`
- `conv_ready` in 1: from `conv2d.ready`
- `ReadAddress` in `ADDR_W`, `d_in` out `PIX_W`: `conv2d` read port
- `WriteAddress` in `ADDR_W`, `d_out` in `OUT_W`, `WriteEnable` in 1: `conv2d` write port

## Operation
- N = `IMG_W`*`IMG_H` = 2500.
- The FSM has four states: IDLE → LOAD → RUN → DRAIN → IDLE.
- **IDLE.** `go`=1 moves to LOAD and clears the pixel counter.
- **LOAD.** `s_ready`=1. Each `s_valid&&s_ready` writes `s_data` to in_ram[cnt] and increments cnt. Accepting pixel N-1 moves to RUN, and `s_ready` drops in that same transition.
- **RUN.**
  - `conv_start` pulses high for exactly the first cycle in RUN.
  - The block registers `conv_ready` and waits for its rising edge, which must come after the pulse. That edge moves to DRAIN.
  - A `conv_ready` level that is already high on entry does not count as the edge.
- **Read port (all states).** `d_in` = in_ram[`ReadAddress`] combinationally, as an asynchronous read. `ReadAddress` ≥ N returns 0.
- **Write port (all states).** On a rising `clk` with `WriteEnable`=1, `d_out` is written to out_ram[`WriteAddress`]. `WriteAddress` ≥ N is dropped.
- **DRAIN.**
  - out_ram is read synchronously with a zero-bubble prefetch. `m_data` holds word k while `m_valid`=1.
  - `m_data` and `m_valid` stay stable until `m_ready`.
  - `m_last`=1 with word N-1.
  - Acceptance of word N-1 pulses `done` and returns the FSM to IDLE.
- `go` outside IDLE is ignored. `s_valid` outside LOAD is ignored, with `s_ready`=0.
- RAM contents are not cleared by reset. A drain after reset without a run returns stale data.

## Timing
- **Reset values:** state=IDLE; `busy`, `done`, `s_ready`, `m_valid`, `m_last`, `conv_start` = 0; `m_data` = 0; counters = 0.
- Reset asserted mid-LOAD, RUN or DRAIN aborts immediately to IDLE. `conv_start` is not re-issued.
- `go` high at edge t gives `busy`=1 and `s_ready`=1 at t+1.
- `d_in` has zero-cycle latency from `ReadAddress`.
- A write at edge t is readable on `d_in`/DRAIN from t+1.
- Last load handshake at edge t gives RUN at t+1 and `conv_start`=1 for the cycle t+1..t+2.
- `conv_ready` rising, seen registered at edge t, gives DRAIN at t+1 and `m_valid`=1 at t+2.
- With `m_ready` held high in DRAIN, the stream runs one word per cycle with no bubbles, for a total of N cycles of `m_valid`.
- `m_ready` low stalls the stream with no data loss and no duplication.

## Structure
- A shared package holds `IMG_W`, `IMG_H`, `PIX_W`, `OUT_W`, `ADDR_W`, the derived N, and the FSM state encoding.
- One sub-module, `frame_ram`, is parameterized by width and depth. It has one write port and a read port that can be asynchronous or synchronous.
- It is instantiated twice:
  - `in_ram` (`PIX_W`, asynchronous read).
  - `out_ram` (`OUT_W`, synchronous read).
- The FSM, counters and stream logic live in the top level.

## Test plan
- **Load ramp.** `go`, then 2500 pixels `s_data`=i mod 4096 with `s_valid` held high. Expect `s_ready` low after the 2500th, and `ReadAddress`=1234 → `d_in`=1234 combinationally. `ReadAddress`=3000 → `d_in`=0.
- **Start pulse.** Expect exactly one `conv_start` cycle after the load. Hold `conv_ready` high from entry: no DRAIN. Drop it, then raise it: DRAIN at +1 and `m_valid` at +2.
- **Write capture and drain.** Write `d_out`=i*3 at every address through `WriteEnable` in RUN, plus one write at address 2600. Drain with `m_ready`=1. Expect 2500 words i*3 on consecutive cycles, `m_last` only on word 2499, a `done` pulse, and no corruption from the address-2600 write.
- **Backpressure.** Drive `m_ready` with a random 30% duty. Expect the sequence unchanged, `m_data` stable while stalled, and no duplicates.
- **Reset mid-operation.** Assert `rst` after 1000 load pixels. Expect `busy`=0, `s_ready`=0 and IDLE on the next cycle. A new `go` plus a full load succeeds.
- **Full system.** Instantiate with `conv2d`, `f_coeff`=200'h050000000400fffeff00000000000000010201000200000001 and a 50×50 image. The drained stream must match the golden output file bit-exact.

Source files
------------

// File: rtl/conv_frame_mem_pkg.sv
// rtl/conv_frame_mem_pkg.sv - shared frame geometry, widths and FSM encoding for conv_frame_mem
package conv_frame_mem_pkg;

  localparam int IMG_W  = 50;
  localparam int IMG_H  = 50;
  localparam int PIX_W  = 12;
  localparam int OUT_W  = PIX_W + 8;
  localparam int ADDR_W = 17;
  localparam int N      = IMG_W * IMG_H;
  localparam int CNT_W  = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/conv_frame_mem_frame_ram.sv
// rtl/conv_frame_mem_frame_ram.sv - single-write-port frame RAM with async or registered read
module frame_ram #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 2500,
  parameter int AW         = 17,
  parameter bit ASYNC_READ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [WIDTH-1:0] w_async;

  // Out-of-range addresses never touch the array: writes drop, reads return zero.
  assign w_wr_ok = i_we && (i_waddr < AW'(DEPTH));
  assign w_rd_ok = i_raddr < AW'(DEPTH);
  assign w_async = w_rd_ok ? r_mem[i_raddr[IW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_waddr[IW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= w_async;
  end

  assign o_rdata = ASYNC_READ ? w_async : r_rdata;

endmodule

// File: rtl/conv_frame_mem.sv
// rtl/conv_frame_mem.sv - conv2d frame memory: host load stream, run handshake, result drain stream
module conv_frame_mem
  import conv_frame_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  output logic              conv_start,
  input  logic              conv_ready,
  input  logic [ADDR_W-1:0] ReadAddress,
  output logic [PIX_W-1:0]  d_in,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [OUT_W-1:0]  d_out,
  input  logic              WriteEnable
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic              r_busy, r_done, r_s_ready, r_m_valid, r_m_last, r_conv_start;
  logic              r_cr, r_seen_low;
  logic              w_in_we, w_out_re;
  logic [ADDR_W-1:0] w_in_waddr, w_out_raddr;

  assign w_in_we     = (r_state == S_LOAD) && s_valid && r_s_ready;
  // Fetch the next word whenever the output register is empty or being consumed.
  assign w_out_re    = (r_state == S_DRAIN) && (!r_m_valid || m_ready) && (r_rd_cnt < CNT_W'(N));
  assign w_in_waddr  = ADDR_W'(r_cnt);
  assign w_out_raddr = ADDR_W'(r_rd_cnt);

  frame_ram #(.WIDTH(PIX_W), .DEPTH(N), .AW(ADDR_W), .ASYNC_READ(1'b1)) u_in_ram (
    .clk(clk), .rst(rst),
    .i_we(w_in_we), .i_waddr(w_in_waddr), .i_wdata(s_data),
    .i_re(1'b0), .i_raddr(ReadAddress), .o_rdata(d_in)
  );

  frame_ram #(.WIDTH(OUT_W), .DEPTH(N), .AW(ADDR_W), .ASYNC_READ(1'b0)) u_out_ram (
    .clk(clk), .rst(rst),
    .i_we(WriteEnable), .i_waddr(WriteAddress), .i_wdata(d_out),
    .i_re(w_out_re), .i_raddr(w_out_raddr), .o_rdata(m_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rd_cnt     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_conv_start <= 1'b0;
      r_cr         <= 1'b0;
      r_seen_low   <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_conv_start <= 1'b0;
      r_cr         <= conv_ready;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state   <= S_LOAD;
            r_busy    <= 1'b1;
            r_s_ready <= 1'b1;
            r_cnt     <= '0;
          end
        end
        S_LOAD: begin
          if (w_in_we) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(N - 1)) begin
              r_state      <= S_RUN;
              r_s_ready    <= 1'b0;
              r_conv_start <= 1'b1;
              r_seen_low   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          // Only a low-to-high transition observed inside RUN counts as completion.
          if (!r_cr) begin
            r_seen_low <= 1'b1;
          end else if (r_seen_low) begin
            r_state  <= S_DRAIN;
            r_rd_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (w_out_re) begin
            r_m_valid <= 1'b1;
            r_m_last  <= (r_rd_cnt == CNT_W'(N - 1));
            r_rd_cnt  <= r_rd_cnt + 1'b1;
          end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
          end
          if (r_m_valid && m_ready && r_m_last) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign conv_start = r_conv_start;

endmodule

// File: tb/tb_conv_frame_mem.sv
// tb/tb_conv_frame_mem.sv - randomized self-checking bench for conv_frame_mem against array models
module tb_conv_frame_mem;
  import conv_frame_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst, go, s_valid, m_ready, conv_ready, WriteEnable;
  logic [PIX_W-1:0]  s_data;
  logic [ADDR_W-1:0] ReadAddress, WriteAddress;
  logic [OUT_W-1:0]  d_out;
  logic              busy, done, s_ready, m_valid, m_last, conv_start;
  logic [OUT_W-1:0]  m_data;
  logic [PIX_W-1:0]  d_in;

  int total = 0;
  int bad   = 0;

  logic [PIX_W-1:0] in_model  [N];
  logic [OUT_W-1:0] out_model [N];

  conv_frame_mem dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .conv_start(conv_start), .conv_ready(conv_ready),
    .ReadAddress(ReadAddress), .d_in(d_in),
    .WriteAddress(WriteAddress), .d_out(d_out), .WriteEnable(WriteEnable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    conv_ready = 1'b1; WriteEnable = 1'b0; WriteAddress = '0; d_out = '0; ReadAddress = '0;
    tick(); tick();
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (s_ready !== 1'b0)    begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    total++; if (m_last !== 1'b0)     begin bad++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    total++; if (conv_start !== 1'b0) begin bad++; $display("FAIL reset_conv_start got=%b exp=0", conv_start); end
    total++; if (m_data !== '0)       begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic start_load();
    go = 1'b1;
    tick();
    go = 1'b0;
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL go_busy got=%b exp=1", busy); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL go_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic feed(input int count, input bit ramp);
    s_valid = 1'b1;
    for (int i = 0; i < count; i++) begin
      s_data = ramp ? PIX_W'(i % 4096) : PIX_W'($urandom);
      in_model[i] = s_data;
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL load_s_ready idx=%0d got=%b exp=1", i, s_ready); end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic load_full(input bit ramp);
    start_load();
    feed(N, ramp);
    total++; if (s_ready !== 1'b0)    begin bad++; $display("FAIL end_s_ready got=%b exp=0", s_ready); end
    total++; if (conv_start !== 1'b1) begin bad++; $display("FAIL start_pulse got=%b exp=1", conv_start); end
    tick();
    total++; if (conv_start !== 1'b0) begin bad++; $display("FAIL start_width got=%b exp=0", conv_start); end
  endtask

  task automatic check_reads(input int nrand);
    int a;
    ReadAddress = ADDR_W'(1234); #1;
    total++; if (d_in !== in_model[1234]) begin bad++; $display("FAIL read_1234 got=%0d exp=%0d", d_in, in_model[1234]); end
    ReadAddress = ADDR_W'(3000); #1;
    total++; if (d_in !== '0) begin bad++; $display("FAIL read_3000 got=%0d exp=0", d_in); end
    ReadAddress = ADDR_W'(N); #1;
    total++; if (d_in !== '0) begin bad++; $display("FAIL read_N got=%0d exp=0", d_in); end
    ReadAddress = ADDR_W'(N - 1); #1;
    total++; if (d_in !== in_model[N-1]) begin bad++; $display("FAIL read_last got=%0d exp=%0d", d_in, in_model[N-1]); end
    for (int k = 0; k < nrand; k++) begin
      a = $urandom_range(N - 1);
      ReadAddress = ADDR_W'(a); #1;
      total++; if (d_in !== in_model[a]) begin bad++; $display("FAIL read_rand addr=%0d got=%0d exp=%0d", a, d_in, in_model[a]); end
    end
  endtask

  task automatic do_writes(input bit triple);
    int starts = 0;
    WriteEnable = 1'b1;
    for (int i = 0; i < N; i++) begin
      WriteAddress = ADDR_W'(i);
      d_out = triple ? OUT_W'(i * 3) : OUT_W'($urandom);
      out_model[i] = d_out;
      if (conv_start) starts++;
      tick();
    end
    WriteAddress = ADDR_W'(2600);
    d_out = OUT_W'(20'hABCDE);
    tick();
    WriteEnable = 1'b0;
    total++; if (starts != 0)      begin bad++; $display("FAIL restart got=%0d exp=0", starts); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL held_ready_drain got=%b exp=0", m_valid); end
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL run_busy got=%b exp=1", busy); end
  endtask

  task automatic conv_edge();
    conv_ready = 1'b0;
    tick(); tick();
    conv_ready = 1'b1;
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL edge_t got=%b exp=0", m_valid); end
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL edge_t1 got=%b exp=0", m_valid); end
    tick();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL edge_t2 got=%b exp=1", m_valid); end
    total++; if (m_data !== out_model[0]) begin bad++; $display("FAIL first_word got=%h exp=%h", m_data, out_model[0]); end
  endtask

  task automatic drain(input int duty);
    int idx = 0, cyc = 0, bubbles = 0, early = 0;
    bit started = 0, stalled = 0;
    logic [OUT_W-1:0] held = '0;
    while (idx < N && cyc < 30000) begin
      m_ready = ($urandom_range(99) < duty);
      if (stalled) begin
        total++; if (m_valid !== 1'b1 || m_data !== held) begin bad++; $display("FAIL stall_stable idx=%0d got=%b/%h exp=1/%h", idx, m_valid, m_data, held); end
      end
      if (done) early++;
      if (m_valid) begin
        started = 1;
        if (m_ready) begin
          total++; if (m_data !== out_model[idx]) begin bad++; $display("FAIL drain_data idx=%0d got=%h exp=%h", idx, m_data, out_model[idx]); end
          total++; if (m_last !== (idx == N - 1)) begin bad++; $display("FAIL drain_last idx=%0d got=%b exp=%b", idx, m_last, (idx == N - 1)); end
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = m_data;
        end
      end else if (started) begin
        bubbles++;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    total++; if (idx != N)      begin bad++; $display("FAIL drain_count got=%0d exp=%0d", idx, N); end
    total++; if (early != 0)    begin bad++; $display("FAIL early_done got=%0d exp=0", early); end
    if (duty >= 100) begin
      total++; if (bubbles != 0) begin bad++; $display("FAIL bubbles got=%0d exp=0", bubbles); end
    end
    total++; if (done !== 1'b1)    begin bad++; $display("FAIL done_pulse got=%b exp=1", done); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL done_busy got=%b exp=0", busy); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL done_m_valid got=%b exp=0", m_valid); end
    tick();
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL done_width got=%b exp=0", done); end
  endtask

  task automatic test_load_ramp();
    int starts = 0;
    load_full(1'b1);
    s_valid = 1'b1; s_data = PIX_W'(12'hFFF);
    for (int k = 0; k < 6; k++) begin
      if (conv_start) starts++;
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL run_s_ready got=%b exp=0", s_ready); end
      tick();
    end
    s_valid = 1'b0;
    total++; if (starts != 0) begin bad++; $display("FAIL extra_start got=%0d exp=0", starts); end
    ReadAddress = '0; #1;
    total++; if (d_in !== in_model[0]) begin bad++; $display("FAIL ignored_svalid got=%0d exp=%0d", d_in, in_model[0]); end
    check_reads(16);
  endtask

  task automatic test_write_drain();
    do_writes(1'b1);
    conv_edge();
    drain(100);
  endtask

  task automatic test_backpressure();
    load_full(1'b0);
    check_reads(16);
    do_writes(1'b0);
    conv_edge();
    drain(30);
  endtask

  task automatic test_reset_mid();
    start_load();
    feed(1000, 1'b0);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_s_ready got=%b exp=0", s_ready); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (conv_start !== 1'b0) begin bad++; $display("FAIL abort_start got=%b exp=0", conv_start); end
    load_full(1'b0);
    check_reads(8);
    do_writes(1'b0);
    conv_edge();
    drain(70);
  endtask

  initial begin
    test_reset();
    test_load_ramp();
    test_write_drain();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
